// File: rtl/hcsr04_pkg.sv
//------------------------------------------------------------------------------
// Module   : hcsr04_pkg
// Purpose  : Shared definitions for the HC-SR04 emulator and the trena benches.
//            It holds the state encoding seen on db_estado and the default
//            timing constants, which assume a 50 MHz clock.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package hcsr04_pkg;

  // State codes, exported on db_estado
  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    MEDE_TRIGGER = 4'd1,
    ESPERA       = 4'd2,
    ECO          = 4'd3,
    DESCANSO     = 4'd4
  } estado_t;

  // Default timing at 50 MHz
  localparam int DEF_TRIG_MIN_CYCLES = 500;      // 10 us
  localparam int DEF_DELAY_CYCLES    = 20000;    // 400 us
  localparam int DEF_CYCLES_PER_CM   = 2941;     // 58.82 us
  localparam int DEF_MAX_CM          = 400;
  localparam int DEF_TIMEOUT_CYCLES  = 1900000;  // 38 ms
  localparam int DEF_HOLDOFF_CYCLES  = 3000;     // 60 us

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hcsr04_contador.sv
//------------------------------------------------------------------------------
// Module   : hcsr04_contador
// Purpose  : Loadable up-counter with clear, enable and a terminal-count flag.
//            The priority order is reset, then clear, then load, then enable.
// Ports    : clock, reset      - clock and synchronous active-high reset
//            clear             - forces the count to zero
//            load, load_value  - loads load_value into the count
//            enable            - increments the count by one
//            last              - terminal value to compare against
//            value             - current count
//            tc                - high while value == last
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hcsr04_contador #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= value + 1'b1;
    end
  end

  assign tc = (value == last);

endmodule

`default_nettype wire

// File: rtl/hcsr04_emulador.sv
//------------------------------------------------------------------------------
// Module   : hcsr04_emulador
// Purpose  : Emulates the responder side of an HC-SR04 ultrasonic sensor.
//            A trigger pulse that stays high for at least TRIG_MIN_CYCLES
//            starts a measurement. After a fixed flight delay, echo is driven
//            high for distancia * CYCLES_PER_CM cycles. An out-of-range
//            distance gives TIMEOUT_CYCLES instead. A holdoff period follows.
// Ports    : clock, reset - 50 MHz clock and synchronous active-high reset
//            trigger      - trigger input from the measuring circuit
//            distancia    - emulated distance in cm (9-bit unsigned)
//            echo         - registered echo pulse
//            ocupado      - high during espera, eco and descanso
//            db_estado    - current state code
// Config   : HCSR04_EMU_SYNC_EN - when defined, trigger passes through a
//            2-flop synchronizer, which delays trigger timing by 2 cycles.
// Notes    : DELAY_CYCLES must be at least 2.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hcsr04_emulador
  import hcsr04_pkg::*;
#(
  parameter int TRIG_MIN_CYCLES = DEF_TRIG_MIN_CYCLES,
  parameter int DELAY_CYCLES    = DEF_DELAY_CYCLES,
  parameter int CYCLES_PER_CM   = DEF_CYCLES_PER_CM,
  parameter int MAX_CM          = DEF_MAX_CM,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int DUR_MAX = max_int(max_int(TIMEOUT_CYCLES, DELAY_CYCLES),
                                   max_int(HOLDOFF_CYCLES, TRIG_MIN_CYCLES));
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int CYC_W   = $clog2(CYCLES_PER_CM + 1);

  // Trigger sampling. hist_valid marks the point where trig_s holds a real
  // sample rather than a reset value. Without it, a trigger held high through
  // reset release would look like a 0->1 edge.
  logic trig_in;
  logic hist_valid;
  logic trig_s, trig_p, armed;

`ifdef HCSR04_EMU_SYNC_EN
  logic [1:0] sync_ff;
  logic [2:0] vld_pipe;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff  <= '0;
      vld_pipe <= '0;
    end else begin
      sync_ff  <= {sync_ff[0], trigger};
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end
  assign trig_in    = sync_ff[1];
  assign hist_valid = vld_pipe[2];
`else
  logic vld_q;
  always_ff @(posedge clock) begin
    if (reset) vld_q <= 1'b0;
    else       vld_q <= 1'b1;
  end
  assign trig_in    = trigger;
  assign hist_valid = vld_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      trig_s <= 1'b0;
      trig_p <= 1'b0;
      armed  <= 1'b0;
    end else begin
      trig_s <= trig_in;
      trig_p <= trig_s;
      armed  <= armed | (hist_valid & ~trig_s);
    end
  end

  logic rise;
  assign rise = trig_s & ~trig_p & armed;

  // Datapath
  estado_t            state, next_state;
  logic [8:0]         dist_q;
  logic [8:0]         cm_cnt;
  logic               latch_dist;
  logic               in_range;

  logic               dur_clear, dur_load, dur_en, dur_tc;
  logic [DUR_W-1:0]   dur_last, dur_value;
  logic               cyc_clear, cyc_en, cyc_tc;
  logic [CYC_W-1:0]   cyc_value;

  assign in_range = (dist_q != 9'd0) && (dist_q <= 9'(MAX_CM));

  // Counts high trigger cycles in mede_trigger, and the length of espera,
  // timeout-eco and descanso.
  hcsr04_contador #(.WIDTH(DUR_W)) u_dur (
    .clock      (clock),
    .reset      (reset),
    .clear      (dur_clear),
    .load       (dur_load),
    .load_value (DUR_W'(1)),
    .enable     (dur_en),
    .last       (dur_last),
    .value      (dur_value),
    .tc         (dur_tc)
  );

  // Cycles within the current centimetre; wraps every CYCLES_PER_CM cycles.
  assign cyc_en    = (state == ECO) && in_range;
  assign cyc_clear = (state != ECO) || cyc_tc;

  hcsr04_contador #(.WIDTH(CYC_W)) u_cyc (
    .clock      (clock),
    .reset      (reset),
    .clear      (cyc_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (cyc_en),
    .last       (CYC_W'(CYCLES_PER_CM - 1)),
    .value      (cyc_value),
    .tc         (cyc_tc)
  );

  // Only the wrap of the cycle counter matters here; its position does not.
  logic unused_cyc;
  assign unused_cyc = ^cyc_value;

  always_ff @(posedge clock) begin
    if (reset || state != ECO) begin
      cm_cnt <= '0;
    end else if (cyc_tc && in_range) begin
      cm_cnt <= cm_cnt + 9'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dist_q <= '0;
    end else if (latch_dist) begin
      dist_q <= distancia;
    end
  end

  // FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= INICIAL;
      echo    <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      state   <= next_state;
      echo    <= (next_state == ECO);
      ocupado <= (next_state == ESPERA) || (next_state == ECO) ||
                 (next_state == DESCANSO);
    end
  end

  always_comb begin
    next_state = state;
    dur_clear  = 1'b0;
    dur_load   = 1'b0;
    dur_en     = 1'b0;
    dur_last   = '1;
    latch_dist = 1'b0;
    case (state)
      INICIAL: begin
        // The edge cycle itself is the first high cycle counted.
        if (rise) begin
          next_state = MEDE_TRIGGER;
          dur_load   = 1'b1;
        end else begin
          dur_clear  = 1'b1;
        end
      end
      MEDE_TRIGGER: begin
        if (!trig_s) begin
          dur_clear = 1'b1;
          if (dur_value >= DUR_W'(TRIG_MIN_CYCLES)) begin
            next_state = ESPERA;
            latch_dist = 1'b1;
          end else begin
            next_state = INICIAL;
          end
        end else begin
          // Saturate so that a long trigger cannot wrap the count.
          dur_en = (dur_value < DUR_W'(TRIG_MIN_CYCLES));
        end
      end
      ESPERA: begin
        // Entered one cycle after the qualifying fall, so this state holds
        // DELAY_CYCLES-1 cycles. That makes echo rise DELAY_CYCLES after it.
        dur_last = DUR_W'(DELAY_CYCLES - 2);
        dur_en   = 1'b1;
        if (dur_tc) begin
          next_state = ECO;
          dur_clear  = 1'b1;
        end
      end
      ECO: begin
        dur_last = DUR_W'(TIMEOUT_CYCLES - 1);
        dur_en   = 1'b1;
        if (in_range ? (cyc_tc && (cm_cnt == dist_q - 9'd1)) : dur_tc) begin
          next_state = DESCANSO;
          dur_clear  = 1'b1;
        end
      end
      DESCANSO: begin
        dur_last = DUR_W'(HOLDOFF_CYCLES - 1);
        dur_en   = 1'b1;
        if (dur_tc) begin
          next_state = INICIAL;
          dur_clear  = 1'b1;
        end
      end
      default: begin
        next_state = INICIAL;
        dur_clear  = 1'b1;
      end
    endcase
  end

  assign db_estado = state;

endmodule

`default_nettype wire

// File: tb/tb_hcsr04_emulador.sv
//------------------------------------------------------------------------------
// Module   : tb_hcsr04_emulador
// Purpose  : Directed self-checking bench for hcsr04_emulador. It uses reduced
//            timing parameters so that each measurement stays short. Expected
//            values are computed by hand from those parameters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_hcsr04_emulador;

  localparam int TMIN  = 5;
  localparam int DLY   = 20;
  localparam int CPC   = 7;
  localparam int MAXCM = 40;
  localparam int TOUT  = 300;
  localparam int HOLD  = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = 9'd0;
  logic       echo;
  logic       ocupado;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_bad = 0;

  hcsr04_emulador #(
    .TRIG_MIN_CYCLES (TMIN),
    .DELAY_CYCLES    (DLY),
    .CYCLES_PER_CM   (CPC),
    .MAX_CM          (MAXCM),
    .TIMEOUT_CYCLES  (TOUT),
    .HOLDOFF_CYCLES  (HOLD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .distancia (distancia),
    .echo      (echo),
    .ocupado   (ocupado),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Trigger high for exactly n sampled cycles.
  task automatic pulse(input int n);
    @(posedge clock);
    #1 trigger = 1'b1;
    repeat (n) @(posedge clock);
    #1 trigger = 1'b0;
  endtask

  // Follows one measurement after the trigger fall. k=1 is the edge that
  // samples the fall. Optionally pulses trigger again from retrig_at for 8
  // cycles, and changes distancia at dist_change_at.
  task automatic measure(input string tag, input int exp_w,
                         input int retrig_at, input int dist_change_at);
    int   oc_r = -1, e_r = -1, e_f = -1, oc_f = -1, pulses = 0, db2 = -1;
    logic prev = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 2) db2 = int'(db_estado);
      if (ocupado && oc_r < 0) oc_r = k;
      if (echo && !prev) pulses++;
      if (echo && e_r < 0) e_r = k;
      if (!echo && e_r >= 0 && e_f < 0) e_f = k;
      prev = echo;
      if (!ocupado && oc_r >= 0 && oc_f < 0) begin
        oc_f = k;
        break;
      end
      trigger = (retrig_at > 0) && (k >= retrig_at) && (k < retrig_at + 8);
      if (k == dist_change_at) distancia = 9'd3;
    end
    trigger = 1'b0;
    check_val({tag, "_ocup_rise"},  oc_r,        2);
    check_val({tag, "_db_espera"},  db2,         2);
    check_val({tag, "_echo_rise"},  e_r,         DLY + 1);
    check_val({tag, "_echo_width"}, e_f - e_r,   exp_w);
    check_val({tag, "_holdoff"},    oc_f - e_f,  HOLD);
    check_val({tag, "_n_echo"},     pulses,      1);
  endtask

  int seen_echo, seen_ocup, seen_db;

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_echo",    int'(echo),      0);
    check_val("rst_ocupado", int'(ocupado),   0);
    check_val("rst_estado",  int'(db_estado), 0);
    reset = 1'b0;
    repeat (3) @(posedge clock);

    // Distance change during espera must not affect the measurement
    distancia = 9'd10;  pulse(6); measure("d10", 70, 0, 5);
    distancia = 9'd40;  pulse(TMIN); measure("d40_min_trig", 280, 0, 0);
    distancia = 9'd41;  pulse(6); measure("d41", TOUT, 0, 0);
    distancia = 9'd0;   pulse(6); measure("d0", TOUT, 0, 0);
    distancia = 9'd450; pulse(6); measure("d450", TOUT, 0, 0);
    distancia = 9'd1;   pulse(6); measure("d1", 7, 0, 0);
    distancia = 9'd10;  pulse(6); measure("retrig_eco", 70, DLY + 10, 0);
    distancia = 9'd10;  pulse(6); measure("retrig_desc", 70, DLY + 1 + 70 + 2, 0);

    // A trigger that is too short produces no echo
    distancia = 9'd10;
    pulse(TMIN - 1);
    seen_echo = 0; seen_ocup = 0; seen_db = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k == 1) check_val("short_db_mede", int'(db_estado), 1);
      if (k == 2) check_val("short_db_back", int'(db_estado), 0);
      if (echo) seen_echo++;
      if (ocupado) seen_ocup++;
    end
    check_val("short_no_echo", seen_echo, 0);
    check_val("short_no_ocup", seen_ocup, 0);

    // Reset pulsed during eco, with trigger held high through reset release
    distancia = 9'd10;
    pulse(6);
    repeat (30) @(posedge clock);
    @(negedge clock);
    check_val("pre_rst_echo", int'(echo), 1);
    reset   = 1'b1;
    trigger = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_val("midrst_echo",  int'(echo),      0);
    check_val("midrst_state", int'(db_estado), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen_ocup = 0; seen_db = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ocupado) seen_ocup++;
      if (db_estado != 4'd0) seen_db++;
    end
    check_val("held_trig_no_ocup",  seen_ocup, 0);
    check_val("held_trig_no_state", seen_db,   0);
    trigger = 1'b0;
    repeat (3) @(posedge clock);
    distancia = 9'd10; pulse(6); measure("after_rst", 70, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
